// File: rtl/ascon_permutation.sv
// Iterative Ascon-p[rnd] engine: one round (pc -> ps -> pl) per clock on a 320-bit state.
// Word s0 occupies bits [319:256] and s4 occupies bits [63:0].

module pc (
    input  logic [319:0] state_in,
    input  logic [3:0]   rnd,
    output logic [319:0] state_out
);
    // Round index 4..15 maps to constant {~i, i} with i = rnd - 4 (0xf0 .. 0x4b).
    logic [3:0] idx;

    assign idx       = rnd - 4'd4;
    assign state_out = {state_in[319:192],
                        state_in[191:128] ^ {56'd0, ~idx, idx},
                        state_in[127:0]};
endmodule

module ascon_permutation (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   rnd_start,
    input  logic [319:0] state_in,
    output logic [319:0] state_out,
    output logic         busy,
    output logic         done
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [319:0] state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [319:0] pc_out;
    logic [63:0]  x0, x1, x2, x3, x4;
    logic [63:0]  y0, y1, y2, y3, y4;
    logic [319:0] round_out;

    function automatic logic [4:0] sbox(input logic [4:0] x);
        logic [4:0] y;
        case (x)
            5'h00: y = 5'h04; 5'h01: y = 5'h0b; 5'h02: y = 5'h1f; 5'h03: y = 5'h14;
            5'h04: y = 5'h1a; 5'h05: y = 5'h15; 5'h06: y = 5'h09; 5'h07: y = 5'h02;
            5'h08: y = 5'h1b; 5'h09: y = 5'h05; 5'h0a: y = 5'h08; 5'h0b: y = 5'h12;
            5'h0c: y = 5'h1d; 5'h0d: y = 5'h03; 5'h0e: y = 5'h06; 5'h0f: y = 5'h1c;
            5'h10: y = 5'h1e; 5'h11: y = 5'h13; 5'h12: y = 5'h07; 5'h13: y = 5'h0e;
            5'h14: y = 5'h00; 5'h15: y = 5'h0d; 5'h16: y = 5'h11; 5'h17: y = 5'h18;
            5'h18: y = 5'h10; 5'h19: y = 5'h0c; 5'h1a: y = 5'h01; 5'h1b: y = 5'h19;
            5'h1c: y = 5'h16; 5'h1d: y = 5'h0a; 5'h1e: y = 5'h0f; default: y = 5'h17;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    pc u_pc (
        .state_in  (state_q),
        .rnd       (rnd_q),
        .state_out (pc_out)
    );

    // Substitution layer: the S-box runs down each of the 64 bit columns.
    always_comb begin
        x0 = '0;
        x1 = '0;
        x2 = '0;
        x3 = '0;
        x4 = '0;
        for (int i = 0; i < 64; i++) begin
            {x0[i], x1[i], x2[i], x3[i], x4[i]} =
                sbox({pc_out[256+i], pc_out[192+i], pc_out[128+i], pc_out[64+i], pc_out[i]});
        end
    end

    assign y0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    assign y1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    assign y2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    assign y3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    assign y4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);

    assign round_out = {y0, y1, y2, y3, y4};

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rnd_d   = rnd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    state_d = state_in;
                    rnd_d   = (rnd_start < 4'd4) ? 4'd4 : rnd_start;
                    busy_d  = 1'b1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                state_d = round_out;
                if (rnd_q == 4'hF) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    fsm_d  = IDLE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rnd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign state_out = state_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule
